fifo_mac_reader: RTL and testbench

FIFO_MAC_READER -- requirements
Module: fifo_mac_reader

---
 rtl/fifo_mac_reader.sv | 108 ++++++++++
 tb/tb_fifo_mac_reader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_mac_reader.sv
// Streams LEN operand pairs out of two registered-output FIFOs and accumulates
// their unsigned dot product into acc_out, pulsing done once the job completes.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  S_IDLE | waiting for start; clr may zero the accumulator; result held
//  S_RUN  | issuing paired reads and accumulating returned products
//  S_DONE | one-cycle completion pulse, acc_out holds the final sum
module fifo_mac_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int LEN        = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clr,
    input  logic                  a_empty,
    input  logic                  b_empty,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  a_rden,
    output logic                  b_rden,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LEN_C = 8'(LEN);

    state_t                  state;
    state_t                  state_nxt;
    logic [7:0]              issue_left;
    logic [7:0]              acc_left;
    logic                    pending;
    logic                    rd_ok;
    logic                    last_acc;
    logic [2*DATA_WIDTH-1:0] product;
    logic [ACC_WIDTH-1:0]    product_ext;
    logic [ACC_WIDTH-1:0]    acc_q;

    // Both strobes come from one term so the FIFOs can never drift apart.
    assign rd_ok    = (state == S_RUN) && !a_empty && !b_empty && (issue_left != 8'd0);
    assign a_rden   = rd_ok;
    assign b_rden   = rd_ok;
    assign last_acc = pending && (acc_left == 8'd1);

    assign product     = a_data * b_data;
    assign product_ext = ACC_WIDTH'(product);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_acc) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Down-counters: issue_left gates new reads, acc_left reaching 1 with a
    // product pending marks the final accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_left <= 8'd0;
            acc_left   <= 8'd0;
            pending    <= 1'b0;
            acc_q      <= '0;
        end else if (state == S_IDLE) begin
            pending <= 1'b0;
            if (start) begin
                acc_q      <= '0;
                issue_left <= LEN_C;
                acc_left   <= LEN_C;
            end else if (clr) begin
                acc_q <= '0;
            end
        end else begin
            pending <= rd_ok;
            if (rd_ok) begin
                issue_left <= issue_left - 8'd1;
            end
            if (pending) begin
                acc_q    <= acc_q + product_ext;
                acc_left <= acc_left - 8'd1;
            end
        end
    end

    assign acc_out = acc_q;
    assign busy    = (state == S_RUN);
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_fifo_mac_reader.sv
// Randomised scoreboard bench for fifo_mac_reader: two instances (24- and 16-bit
// accumulators) share behavioural FIFO models; a monitor checks each done pulse.
module tb_fifo_mac_reader;

    localparam int DW  = 8;
    localparam int LEN = 8;

    typedef struct {
        longint sum;
        int     lat;
        int     start_cyc;
        int     start_reads;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          clr = 1'b0;
    logic          a_hold = 1'b0;
    logic          b_hold = 1'b0;
    logic          a_empty, b_empty;
    logic [DW-1:0] a_data, b_data;
    logic          a_rden, b_rden, busy, done;
    logic [23:0]   acc_out;
    logic          a_rden16, b_rden16, busy16, done16;
    logic [15:0]   acc16;
    logic [DW-1:0] a_mem [0:4095];
    logic [DW-1:0] b_mem [0:4095];
    int            a_wr = 0, b_wr = 0, a_rd = 0, b_rd = 0;
    int            cyc = 0, reads_total = 0;
    int            total = 0, bad = 0;
    longint        cur_sum;
    exp_t          exp_q[$];
    exp_t          mon_e;
    logic          done_prev = 1'b0;

    fifo_mac_reader #(.DATA_WIDTH(DW), .ACC_WIDTH(24), .LEN(LEN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
        .a_empty(a_empty), .b_empty(b_empty), .a_data(a_data), .b_data(b_data),
        .a_rden(a_rden), .b_rden(b_rden), .acc_out(acc_out), .busy(busy), .done(done)
    );

    fifo_mac_reader #(.DATA_WIDTH(DW), .ACC_WIDTH(16), .LEN(LEN)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
        .a_empty(a_empty), .b_empty(b_empty), .a_data(a_data), .b_data(b_data),
        .a_rden(a_rden16), .b_rden(b_rden16), .acc_out(acc16), .busy(busy16), .done(done16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Registered-output FIFOs, reset by the same rst_n as the DUT.
    assign a_empty = (a_rd >= a_wr) || a_hold;
    assign b_empty = (b_rd >= b_wr) || b_hold;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rd   <= 0;
            b_rd   <= 0;
            a_data <= '0;
            b_data <= '0;
        end else begin
            if (a_rden) begin
                a_data      <= a_mem[a_rd[11:0]];
                a_rd        <= a_rd + 1;
                reads_total <= reads_total + 1;
            end
            if (b_rden) begin
                b_data <= b_mem[b_rd[11:0]];
                b_rd   <= b_rd + 1;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0 random, 1 A=1..LEN / B=2, 2 all 255
    task automatic fill(input int mode);
        int va, vb;
        cur_sum = 0;
        for (int i = 0; i < LEN; i++) begin
            case (mode)
                1:       begin va = i + 1; vb = 2; end
                2:       begin va = 255;   vb = 255; end
                default: begin va = int'($urandom_range(0, 255)); vb = int'($urandom_range(0, 255)); end
            endcase
            a_mem[a_wr[11:0]] = va[DW-1:0];
            b_mem[b_wr[11:0]] = vb[DW-1:0];
            a_wr++;
            b_wr++;
            cur_sum += longint'(va) * longint'(vb);
        end
    endtask

    task automatic run_job(input bit stall_a, input int stall_after, input int stall_len,
                           input bit b2b, input bit poke_start, input bit poke_clr,
                           input bit clr_with_start);
        exp_t e;
        int   waited;
        e.sum         = cur_sum;
        e.lat         = LEN + 1 + stall_len;
        e.start_cyc   = cyc + 1;
        e.start_reads = reads_total;
        exp_q.push_back(e);
        start = 1'b1;
        clr   = clr_with_start;
        step();
        start = 1'b0;
        clr   = 1'b0;
        chk("busy_after_start", busy, 1);
        if (b2b) begin
            for (int i = 0; i < LEN; i++) begin
                chk("b2b_rden", a_rden, 1);
                step();
            end
            chk("rden_after_len", a_rden, 0);
        end
        if (poke_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        if (poke_clr) begin
            clr = 1'b1;
            step();
            clr = 1'b0;
        end
        if (stall_len > 0) begin
            waited = 0;
            while ((reads_total - e.start_reads) < stall_after && waited < 200) begin
                step();
                waited++;
            end
            chk("stall_reach", reads_total - e.start_reads, stall_after);
            if (stall_a) a_hold = 1'b1; else b_hold = 1'b1;
            #1;
            for (int i = 0; i < stall_len; i++) begin
                chk("stall_gap_rden", a_rden, 0);
                step();
            end
            a_hold = 1'b0;
            b_hold = 1'b0;
        end
        waited = 0;
        while (!done && waited < 1000) begin
            step();
            waited++;
        end
        chk("done_seen", done, 1);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("idle_hold_acc", acc_out, e.sum & 64'hFFFFFF);
            chk("idle_no_done", done, 0);
        end
    endtask

    // Monitor: pops one expectation per done pulse; also checks strobe legality.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            done_prev = 1'b0;
        end else begin
            chk("rden_pair", a_rden, b_rden);
            chk("w16_ctrl_match", {a_rden16, b_rden16, busy16, done16}, {a_rden, b_rden, busy, done});
            if (a_empty || b_empty) chk("rden_when_empty", a_rden, 0);
            if (!busy) chk("rden_outside_run", a_rden, 0);
            if (done) begin
                chk("done_not_busy", busy, 0);
                chk("done_single_cycle", done_prev, 0);
                chk("done_has_expect", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("acc24_final", acc_out, mon_e.sum & 64'hFFFFFF);
                    chk("acc16_final", acc16, mon_e.sum & 64'hFFFF);
                    chk("done_latency", cyc - mon_e.start_cyc, mon_e.lat);
                    chk("reads_per_job", reads_total - mon_e.start_reads, LEN);
                end
            end
            done_prev = done;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     base, waited, sa, sl;
        longint partial;

        // Reset with non-empty FIFOs and start held high.
        #1 rst_n = 1'b0;
        fill(0);
        start = 1'b1;
        repeat (3) step();
        chk("rst_acc", acc_out, 0);
        chk("rst_acc16", acc16, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rden", {a_rden, b_rden}, 0);
        start = 1'b0;
        a_wr  = 0;
        b_wr  = 0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle_after_rst", busy, 0);

        // Basic job: 1..8 times 2 = 72, reads back-to-back.
        fill(1);
        run_job(0, 0, 0, 1, 0, 0, 0);

        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_in_idle", acc_out, 0);

        // Stall: B empty for 3 cycles after 4 reads.
        fill(1);
        run_job(0, 4, 3, 0, 0, 0, 0);

        // Wrap: 8 x 255*255 = 520200; 16-bit instance wraps to 61448.
        fill(2);
        run_job(0, 0, 0, 1, 0, 0, 0);

        // start and clr pulsed mid-run are ignored.
        fill(0);
        run_job(0, 3, 2, 0, 1, 1, 0);

        // start with clr in IDLE: start wins.
        fill(0);
        run_job(1, 5, 1, 0, 0, 0, 1);

        // Reset after three accumulations aborts the job.
        base = a_wr;
        fill(0);
        partial = 0;
        for (int i = 0; i < 3; i++)
            partial += longint'(a_mem[base + i]) * longint'(b_mem[base + i]);
        start = 1'b1;
        step();
        start  = 1'b0;
        waited = 0;
        while ((a_rd - base) < 4 && waited < 200) begin
            step();
            waited++;
        end
        chk("abort_partial_acc", acc_out, partial);
        rst_n = 1'b0;
        #1;
        chk("abort_acc", acc_out, 0);
        chk("abort_acc16", acc16, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rden", {a_rden, b_rden}, 0);
        a_wr = 0;
        b_wr = 0;
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("abort_no_done", done, 0);
        end
        fill(0);
        run_job(0, 0, 0, 1, 0, 0, 0);

        // Randomised jobs.
        for (int j = 0; j < 20; j++) begin
            fill(0);
            sl = int'($urandom_range(0, 4));
            sa = int'($urandom_range(2, LEN - 1));
            run_job(1'($urandom_range(0, 1)), sa, sl, 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                clr = 1'b1;
                step();
                clr = 1'b0;
                chk("rand_clr_idle", acc_out, 0);
            end
            repeat ($urandom_range(0, 3)) step();
        end

        repeat (4) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
